// File: rtl/multi0_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi0_pkg
// Description : Shared types and constants for the start/done initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package multi0_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESPOND = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam int c_default_width = 32;
  localparam int c_timer_w       = 8;
  localparam int c_count_w       = 16;

endpackage
`default_nettype wire

// File: rtl/multi0_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : multi0_initiator_if
// Description : Request, response and unit-side signals of the initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi0_initiator_if
  import multi0_pkg::*;
#(
  parameter int WIDTH = c_default_width
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_timeout;
  logic             start;
  logic [WIDTH-1:0] inp;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             unit_reset;

  // master: the initiator itself
  modport master (
    input  req_valid, req_data, rsp_ready, done, out,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, start, inp, unit_reset
  );

  // slave: upstream requester, response consumer and the unit combined
  modport slave (
    output req_valid, req_data, rsp_ready, done, out,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, start, inp, unit_reset
  );

endinterface
`default_nettype wire

// File: rtl/multi0_initiator.sv
`default_nettype none
// ============================================================================
// Module      : multi0_initiator
// Description : Drives one start/done transaction at a time, with timeout
//               and unit recovery reset.
// Revision    : 1.0 - initial release
// ============================================================================
module multi0_initiator
  import multi0_pkg::*;
#(
  parameter int WIDTH   = c_default_width,
  parameter int TIMEOUT = 15
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  multi0_initiator_if.master        bus,
  output logic                      busy,
  output logic                      protocol_err,
  output logic [c_count_w-1:0]      txn_count
);

  // Last WAIT cycle index; TIMEOUT is limited to 1..255 so this fits the timer.
  localparam logic [c_timer_w-1:0] c_limit = c_timer_w'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state;
  logic [WIDTH-1:0]      r_inp;
  logic [WIDTH-1:0]      w_inp;
  logic [WIDTH-1:0]      r_rsp_data;
  logic [WIDTH-1:0]      w_rsp_data;
  logic                  r_rsp_timeout;
  logic                  w_rsp_timeout;
  logic                  r_unit_reset;
  logic                  w_unit_reset;
  logic [c_timer_w-1:0]  r_count;
  logic [c_timer_w-1:0]  w_count;
  logic                  r_perr;
  logic                  w_perr;
  logic [c_count_w-1:0]  r_txn;
  logic [c_count_w-1:0]  w_txn;
  logic                  r_busy;
  logic                  w_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      r_inp         <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_unit_reset  <= 1'b0;
      r_count       <= '0;
      r_perr        <= 1'b0;
      r_txn         <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_inp         <= w_inp;
      r_rsp_data    <= w_rsp_data;
      r_rsp_timeout <= w_rsp_timeout;
      r_unit_reset  <= w_unit_reset;
      r_count       <= w_count;
      r_perr        <= w_perr;
      r_txn         <= w_txn;
      r_busy        <= w_busy;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_inp         = r_inp;
    w_rsp_data    = r_rsp_data;
    w_rsp_timeout = r_rsp_timeout;
    w_unit_reset  = 1'b0;
    w_count       = r_count;
    w_txn         = r_txn;
    // Only WAIT consumes done; anywhere else it is a protocol violation.
    w_perr        = r_perr | (bus.done && (r_state != ST_WAIT));

    case (r_state)
      ST_INIT: begin
        // First INIT cycle raises unit_reset, second leaves for IDLE.
        if (!r_unit_reset) begin
          w_unit_reset = 1'b1;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_inp   = bus.req_data;
          w_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_count = '0;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a coincident timeout.
        if (bus.done) begin
          w_rsp_data    = bus.out;
          w_rsp_timeout = 1'b0;
          w_state       = ST_RESPOND;
        end else if (r_count == c_limit) begin
          w_rsp_data    = '0;
          w_rsp_timeout = 1'b1;
          w_state       = ST_RESPOND;
        end else begin
          w_count = r_count + c_timer_w'(1);
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          if (r_rsp_timeout) begin
            w_unit_reset = 1'b1;
            w_state      = ST_RECOVER;
          end else begin
            w_txn   = r_txn + c_count_w'(1);
            w_state = ST_IDLE;
          end
        end
      end
      ST_RECOVER: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_INIT;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.rsp_valid   = (r_state == ST_RESPOND);
  assign bus.start       = (r_state == ST_ISSUE);
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.inp         = r_inp;
  assign bus.unit_reset  = r_unit_reset;
  assign busy            = r_busy;
  assign protocol_err    = r_perr;
  assign txn_count       = r_txn;

endmodule
`default_nettype wire
